// File: rtl/fgpa_draw_pkg.sv
// Shared types and constants for the frame draw sequencer and its command FIFO.
package fgpa_draw_pkg;

    // Sequencer states, in the order a frame walks through them.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_CLEAR_WAIT,
        ST_FETCH,
        ST_ISSUE,
        ST_DRAW_WAIT,
        ST_SWAP
    } seq_state_t;

    // Draw engine opcodes.
    localparam logic [3:0] OP_NOP      = 4'h0;
    localparam logic [3:0] OP_LINE     = 4'h1;
    localparam logic [3:0] OP_TRIANGLE = 4'h2;
    localparam logic [3:0] OP_FILL_TRI = 4'h3;
    localparam logic [3:0] OP_RECT     = 4'h4;

    // Default SDRAM bases of the two pixel buffers.
    localparam logic [31:0] DEF_BUF0_ADDR = 32'h0000_0000;
    localparam logic [31:0] DEF_BUF1_ADDR = 32'h0012_C000;

    // One queued draw command: opcode, three vertices, colour, end-of-frame flag.
    typedef struct packed {
        logic [3:0]  opcode;
        logic [15:0] ax;
        logic [15:0] ay;
        logic [15:0] bx;
        logic [15:0] by;
        logic [15:0] cx;
        logic [15:0] cy;
        logic [23:0] colour;
        logic        last;
    } draw_cmd_t;

    localparam int unsigned DRAW_CMD_W = $bits(draw_cmd_t);

    // Base address of the buffer that is not currently the back buffer.
    function automatic logic [31:0] other_buffer(input logic [31:0] cur,
                                                 input logic [31:0] buf0,
                                                 input logic [31:0] buf1);
        return (cur == buf1) ? buf0 : buf1;
    endfunction

endpackage

// File: rtl/draw_cmd_fifo.sv
// Single-clock show-ahead FIFO for draw commands; the head entry is always on dout.
module draw_cmd_fifo
    import fgpa_draw_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = DRAW_CMD_W
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    // Next pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents need no reset since empty gates every read.
    always_ff @(posedge sys_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/frame_draw_sequencer.sv
// Per-frame scheduler: clears the back buffer on a frame tick, feeds queued
// commands to the draw engine one at a time, then swaps buffers on the last one.
module frame_draw_sequencer
    import fgpa_draw_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] BUF0_ADDR  = DEF_BUF0_ADDR,
    parameter logic [31:0] BUF1_ADDR  = DEF_BUF1_ADDR
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_opcode,
    input  logic [15:0] cmd_ax,
    input  logic [15:0] cmd_ay,
    input  logic [15:0] cmd_bx,
    input  logic [15:0] cmd_by,
    input  logic [15:0] cmd_cx,
    input  logic [15:0] cmd_cy,
    input  logic [23:0] cmd_colour,
    input  logic        cmd_last,
    output logic        clear_start,
    input  logic        clear_done,
    output logic        draw_en,
    output logic [3:0]  draw_opcode,
    output logic [15:0] draw_ax,
    output logic [15:0] draw_ay,
    output logic [15:0] draw_bx,
    output logic [15:0] draw_by,
    output logic [15:0] draw_cx,
    output logic [15:0] draw_cy,
    output logic [23:0] draw_colour,
    input  logic        draw_done,
    output logic        swap_buffer,
    output logic [31:0] base_addr,
    output logic        busy,
    output logic [7:0]  frame_drops
);

    seq_state_t  state_q, state_d;
    draw_cmd_t   issue_q, issue_d;
    logic [31:0] base_q, base_d;
    logic [7:0]  drops_q, drops_d;

    draw_cmd_t   cmd_in;
    draw_cmd_t   fifo_dout;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;

    assign cmd_in = '{opcode: cmd_opcode, ax: cmd_ax, ay: cmd_ay,
                      bx: cmd_bx, by: cmd_by, cx: cmd_cx, cy: cmd_cy,
                      colour: cmd_colour, last: cmd_last};

    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;

    draw_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DRAW_CMD_W)
    ) u_fifo (
        .sys_clk (sys_clk),
        .reset   (reset),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .din     (cmd_in),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Frame sequencing: next state, Moore pulses and the FIFO pop.
    always_comb begin
        state_d     = state_q;
        clear_start = 1'b0;
        draw_en     = 1'b0;
        swap_buffer = 1'b0;
        fifo_pop    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                clear_start = 1'b1;
                state_d     = ST_CLEAR_WAIT;
            end
            ST_CLEAR_WAIT: begin
                if (clear_done) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                draw_en = 1'b1;
                state_d = ST_DRAW_WAIT;
            end
            ST_DRAW_WAIT: begin
                if (draw_done) begin
                    state_d = issue_q.last ? ST_SWAP : ST_FETCH;
                end
            end
            ST_SWAP: begin
                swap_buffer = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath next values: operand capture, buffer toggle, saturating drop count.
    always_comb begin
        issue_d = issue_q;
        base_d  = base_q;
        drops_d = drops_q;
        if (fifo_pop) begin
            issue_d = fifo_dout;
        end
        if (state_q == ST_SWAP) begin
            base_d = other_buffer(base_q, BUF0_ADDR, BUF1_ADDR);
        end
        if (frame_start && (state_q != ST_IDLE) && (drops_q != 8'hFF)) begin
            drops_d = drops_q + 8'd1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            issue_q <= '0;
            base_q  <= BUF1_ADDR;
            drops_q <= '0;
        end else begin
            state_q <= state_d;
            issue_q <= issue_d;
            base_q  <= base_d;
            drops_q <= drops_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign base_addr   = base_q;
    assign frame_drops = drops_q;
    assign draw_opcode = (issue_q.opcode == OP_NOP) ? OP_NOP : issue_q.opcode;
    assign draw_ax     = issue_q.ax;
    assign draw_ay     = issue_q.ay;
    assign draw_bx     = issue_q.bx;
    assign draw_by     = issue_q.by;
    assign draw_cx     = issue_q.cx;
    assign draw_cy     = issue_q.cy;
    assign draw_colour = issue_q.colour;

endmodule

// File: tb/tb_frame_draw_sequencer.sv
// Self-checking bench for frame_draw_sequencer: event-level reference model
// checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_frame_draw_sequencer;
    import fgpa_draw_pkg::*;

    localparam int          DEPTH = 8;
    localparam logic [31:0] B0    = 32'h0000_0000;
    localparam logic [31:0] B1    = 32'h0012_C000;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic        reset, frame_start, cmd_valid, cmd_last, clear_done, draw_done;
    logic [3:0]  cmd_opcode;
    logic [15:0] cmd_ax, cmd_ay, cmd_bx, cmd_by, cmd_cx, cmd_cy;
    logic [23:0] cmd_colour;
    logic        cmd_ready, clear_start, draw_en, swap_buffer, busy;
    logic [3:0]  draw_opcode;
    logic [15:0] draw_ax, draw_ay, draw_bx, draw_by, draw_cx, draw_cy;
    logic [23:0] draw_colour;
    logic [31:0] base_addr;
    logic [7:0]  frame_drops;

    frame_draw_sequencer #(
        .FIFO_DEPTH (DEPTH),
        .BUF0_ADDR  (B0),
        .BUF1_ADDR  (B1)
    ) dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .frame_start (frame_start),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_opcode  (cmd_opcode),
        .cmd_ax      (cmd_ax),
        .cmd_ay      (cmd_ay),
        .cmd_bx      (cmd_bx),
        .cmd_by      (cmd_by),
        .cmd_cx      (cmd_cx),
        .cmd_cy      (cmd_cy),
        .cmd_colour  (cmd_colour),
        .cmd_last    (cmd_last),
        .clear_start (clear_start),
        .clear_done  (clear_done),
        .draw_en     (draw_en),
        .draw_opcode (draw_opcode),
        .draw_ax     (draw_ax),
        .draw_ay     (draw_ay),
        .draw_bx     (draw_bx),
        .draw_by     (draw_by),
        .draw_cx     (draw_cx),
        .draw_cy     (draw_cy),
        .draw_colour (draw_colour),
        .draw_done   (draw_done),
        .swap_buffer (swap_buffer),
        .base_addr   (base_addr),
        .busy        (busy),
        .frame_drops (frame_drops)
    );

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    // The model tracks which event the frame is waiting for and the cycle in
    // which each one-cycle pulse must appear, using a queue for the FIFO.
    draw_cmd_t   mq[$];
    draw_cmd_t   m_cur;
    bit          m_ok = 1'b0;
    bit          m_busy, m_wclr, m_fetch, m_wdraw;
    bit          m_clr, m_drw, m_swp;
    logic [31:0] m_base;
    int          m_drops;
    int          cnt_clr = 0, cnt_drw = 0, cnt_swp = 0;

    always @(negedge sys_clk) begin : model_proc
        bit        pushed, n_clr, n_drw, n_swp;
        draw_cmd_t inc, exp_ops, act_ops;
        if (clear_start === 1'b1) cnt_clr++;
        if (draw_en === 1'b1)     cnt_drw++;
        if (swap_buffer === 1'b1) cnt_swp++;
        if (m_ok) begin
            exp_ops      = m_cur;
            exp_ops.last = 1'b0;
            act_ops      = {draw_opcode, draw_ax, draw_ay, draw_bx, draw_by,
                            draw_cx, draw_cy, draw_colour, 1'b0};
            chk("cmd_ready",   128'(cmd_ready),   128'(mq.size() < DEPTH));
            chk("clear_start", 128'(clear_start), 128'(m_clr));
            chk("draw_en",     128'(draw_en),     128'(m_drw));
            chk("swap_buffer", 128'(swap_buffer), 128'(m_swp));
            chk("busy",        128'(busy),        128'(m_busy));
            chk("base_addr",   128'(base_addr),   128'(m_base));
            chk("frame_drops", 128'(frame_drops), 128'(m_drops));
            chk("operands",    128'(act_ops),     128'(exp_ops));
        end
        if (reset === 1'b1) begin
            mq.delete();
            m_cur  = '0;
            {m_busy, m_wclr, m_fetch, m_wdraw, m_clr, m_drw, m_swp} = '0;
            m_base  = B1;
            m_drops = 0;
            m_ok    = 1'b1;
        end else if (m_ok) begin
            pushed = cmd_valid && (mq.size() < DEPTH);
            inc    = {cmd_opcode, cmd_ax, cmd_ay, cmd_bx, cmd_by, cmd_cx, cmd_cy,
                      cmd_colour, cmd_last};
            n_clr = 1'b0; n_drw = 1'b0; n_swp = 1'b0;
            if (!m_busy) begin
                if (frame_start) begin m_busy = 1'b1; n_clr = 1'b1; end
            end else if (frame_start && m_drops < 255) begin
                m_drops++;
            end
            if (m_clr) m_wclr = 1'b1;
            else if (m_wclr && clear_done) begin m_wclr = 1'b0; m_fetch = 1'b1; end
            else if (m_fetch && mq.size() > 0) begin
                m_cur = mq.pop_front(); m_fetch = 1'b0; n_drw = 1'b1;
            end
            if (m_drw) m_wdraw = 1'b1;
            else if (m_wdraw && draw_done) begin
                m_wdraw = 1'b0;
                if (m_cur.last) n_swp = 1'b1; else m_fetch = 1'b1;
            end
            if (m_swp) begin
                m_busy = 1'b0;
                m_base = (m_base == B1) ? B0 : B1;
            end
            if (pushed) mq.push_back(inc);
            m_clr = n_clr; m_drw = n_drw; m_swp = n_swp;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drive_cmd(input bit last);
        cmd_opcode = 4'($urandom);
        cmd_ax = 16'($urandom); cmd_ay = 16'($urandom);
        cmd_bx = 16'($urandom); cmd_by = 16'($urandom);
        cmd_cx = 16'($urandom); cmd_cy = 16'($urandom);
        cmd_colour = 24'($urandom);
        cmd_last = last;
    endtask

    task automatic push(input bit last, input logic [15:0] ax);
        cmd_valid = 1'b1;
        drive_cmd(last);
        cmd_ax = ax;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Advance until the chosen pulse is seen (0 clear, 1 draw, 2 swap) or the budget expires.
    task automatic wait_pulse(input int sel, input int budget, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            case (sel)
                0:       seen = (clear_start === 1'b1);
                1:       seen = (draw_en === 1'b1);
                default: seen = (swap_buffer === 1'b1);
            endcase
        end
        chk(name, 128'(seen), 128'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, d0, s0;
        logic [15:0] tbl [3];
        reset = 1'b1; frame_start = 1'b0; cmd_valid = 1'b0;
        clear_done = 1'b0; draw_done = 1'b0;
        drive_cmd(1'b0);
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state.
        chk("rst base_addr",   128'(base_addr),   128'(32'h0012C000));
        chk("rst cmd_ready",   128'(cmd_ready),   128'(1));
        chk("rst pulses",      128'({clear_start, draw_en, swap_buffer}), 128'(0));
        chk("rst busy",        128'(busy),        128'(0));
        chk("rst frame_drops", 128'(frame_drops), 128'(0));
        chk("rst draw_ax",     128'(draw_ax),     128'(0));

        // Two complete three-command frames.
        for (int f = 0; f < 2; f++) begin
            tbl[0] = 16'h1111 + 16'(f); tbl[1] = 16'h2222 + 16'(f); tbl[2] = 16'h3333 + 16'(f);
            clear_done = 1'b1; draw_done = 1'b1;
            push(1'b0, tbl[0]); push(1'b0, tbl[1]); push(1'b1, tbl[2]);
            c0 = cnt_clr; d0 = cnt_drw; s0 = cnt_swp;
            pulse_frame();
            chk("clear latency", 128'(clear_start), 128'(1));
            for (int k = 0; k < 3; k++) begin
                wait_pulse(1, 20, "frame draw_en");
                chk("draw order ax", 128'(draw_ax), 128'(tbl[k]));
            end
            wait_pulse(2, 20, "frame swap");
            chk("base before toggle", 128'(base_addr), 128'(f == 0 ? 32'h0012C000 : 32'h00000000));
            tick();
            chk("base after toggle", 128'(base_addr), 128'(f == 0 ? 32'h00000000 : 32'h0012C000));
            chk("busy after swap",   128'(busy),        128'(0));
            chk("clear count",       128'(cnt_clr - c0), 128'(1));
            chk("draw count",        128'(cnt_drw - d0), 128'(3));
            chk("swap count",        128'(cnt_swp - s0), 128'(1));
            chk("no drops",          128'(frame_drops),  128'(0));
        end

        // Fill the FIFO, reject a ninth command, then drain and stall in FETCH.
        clear_done = 1'b0; draw_done = 1'b1;
        for (int i = 0; i < 8; i++) push(1'b0, 16'(16'h0100 + i));
        chk("ready when full", 128'(cmd_ready), 128'(0));
        cmd_valid = 1'b1; drive_cmd(1'b1); tick(); cmd_valid = 1'b0;
        chk("ready still full", 128'(cmd_ready), 128'(0));
        d0 = cnt_drw; s0 = cnt_swp;
        clear_done = 1'b1;
        pulse_frame();
        wait_pulse(1, 20, "full first draw");
        chk("ready after pop", 128'(cmd_ready), 128'(1));
        for (int i = 1; i < 8; i++) begin
            wait_pulse(1, 20, "full drain draw");
            chk("drain order ax", 128'(draw_ax), 128'(16'h0100 + i));
        end
        repeat (8) tick();
        chk("fetch stall busy",  128'(busy),         128'(1));
        chk("fetch stall draws", 128'(cnt_drw - d0), 128'(8));
        chk("fetch stall swaps", 128'(cnt_swp - s0), 128'(0));
        cmd_valid = 1'b1; drive_cmd(1'b1); tick(); cmd_valid = 1'b0;
        chk("pop cycle no draw", 128'(draw_en), 128'(0));
        tick();
        chk("draw at t+2", 128'(draw_en), 128'(1));
        wait_pulse(2, 20, "stall frame swap");
        tick();
        chk("base after stall frame", 128'(base_addr), 128'(32'h00000000));

        // Dropped frame ticks during DRAW_WAIT.
        draw_done = 1'b0; clear_done = 1'b1;
        push(1'b0, 16'hAAAA); push(1'b1, 16'hBBBB);
        pulse_frame();
        wait_pulse(1, 20, "drop frame draw");
        tick();
        c0 = cnt_clr;
        repeat (3) begin pulse_frame(); tick(); end
        chk("drops 3",        128'(frame_drops),   128'(3));
        chk("no extra clear", 128'(cnt_clr - c0),  128'(0));
        frame_start = 1'b1; repeat (300) tick(); frame_start = 1'b0; tick();
        chk("drops saturate", 128'(frame_drops),   128'(255));
        draw_done = 1'b1;
        wait_pulse(2, 30, "drop frame swap");
        tick();
        chk("base after drop frame", 128'(base_addr), 128'(32'h0012C000));

        // Reset while waiting on the draw engine with four entries queued.
        draw_done = 1'b0;
        for (int i = 0; i < 5; i++) push(1'b0, 16'(16'h0500 + i));
        pulse_frame();
        wait_pulse(1, 20, "reset frame draw");
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("mid reset busy",   128'(busy),        128'(0));
        chk("mid reset ready",  128'(cmd_ready),   128'(1));
        chk("mid reset base",   128'(base_addr),   128'(32'h0012C000));
        chk("mid reset drops",  128'(frame_drops), 128'(0));
        chk("mid reset pulses", 128'({clear_start, draw_en, swap_buffer}), 128'(0));
        d0 = cnt_drw; s0 = cnt_swp;
        draw_done = 1'b1; tick(); draw_done = 1'b0;
        repeat (4) tick();
        chk("stray done busy", 128'(busy),         128'(0));
        chk("stray done swap", 128'(cnt_swp - s0), 128'(0));
        pulse_frame();
        repeat (10) tick();
        chk("fifo discarded",  128'(cnt_drw - d0), 128'(0));
        chk("empty fetch busy", 128'(busy),        128'(1));
        reset = 1'b1; repeat (2) tick(); reset = 1'b0;

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            frame_start = ($urandom_range(0, 15) == 0);
            cmd_valid   = ($urandom_range(0, 2) == 0);
            drive_cmd($urandom_range(0, 3) == 0);
            clear_done  = ($urandom_range(0, 3) == 0);
            draw_done   = ($urandom_range(0, 2) == 0);
            reset       = ($urandom_range(0, 999) == 0);
            tick();
        end
        {reset, frame_start, cmd_valid, clear_done, draw_done} = '0;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_draw_sequencer.md
# frame_draw_sequencer

Per-frame scheduler between a host/command source and the draw engine plus SDRAM pixel interface. Buffers draw commands in a small FIFO and starts a back-buffer clear on each frame tick. After the clear, it issues the queued commands one at a time to the draw engine. On the end-of-frame command it requests a pixel-buffer swap and toggles the back-buffer base address.

## Interface
Parameters:
- FIFO_DEPTH, 8 — command FIFO entries; power of two, ≥2
- BUF0_ADDR, 32'h00000000 — SDRAM base of buffer 0
- BUF1_ADDR, 32'h0012C000 — SDRAM base of buffer 1

Ports:
- sys_clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- frame_start  in  1  one-cycle frame tick
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO not full
- cmd_opcode  in  4  draw opcode
- cmd_ax, cmd_ay, cmd_bx, cmd_by, cmd_cx, cmd_cy  in  16 each  vertices
- cmd_colour  in  24  RGB
- cmd_last  in  1  final command of frame
- clear_start  out  1  one-cycle pulse to SDRAM interface
- clear_done  in  1  clear finished
- draw_en  out  1  one-cycle draw start
- draw_opcode  out  4; draw_ax..draw_cy  out  16 each; draw_colour  out  24  operands, registered, held between draws
- draw_done  in  1  draw finished
- swap_buffer  out  1  one-cycle swap request
- base_addr  out  32  current back-buffer base
- busy  out  1  state ≠ IDLE
- frame_drops  out  8  saturating count of ignored frame_start ticks

## Operation
- The FIFO accepts a command when cmd_valid & cmd_ready. It is show-ahead: the head is visible without a pop.
- States and transitions:
  - IDLE: on frame_start → CLEAR.
  - CLEAR: clear_start=1 → CLEAR_WAIT.
  - CLEAR_WAIT: on clear_done → FETCH.
  - FETCH: if FIFO non-empty, pop the head, register the operands, latch last_q=cmd_last → ISSUE; if empty, stay.
  - ISSUE: draw_en=1 → DRAW_WAIT.
  - DRAW_WAIT: on draw_done → SWAP if last_q, otherwise → FETCH.
  - SWAP: swap_buffer=1; base_addr toggles BUF1_ADDR↔BUF0_ADDR → IDLE.
- clear_start, draw_en and swap_buffer are Moore outputs, high exactly one cycle per entry into their state.
- clear_done is ignored outside CLEAR_WAIT. draw_done is ignored outside DRAW_WAIT.
- frame_start in any state other than IDLE increments frame_drops. The count saturates at 255 and does not start a clear.
- A push and a pop in the same cycle on a non-empty FIFO leave the occupancy unchanged. The FIFO never accepts when full, including a same-cycle pop (cmd_ready = !full).
- A frame with no cmd_last entry stalls in FETCH until one arrives. There is no timeout.

## Timing
- Reset values: state=IDLE; FIFO empty; cmd_ready=1; clear_start=draw_en=swap_buffer=busy=0; draw_* operands=0; base_addr=BUF1_ADDR; frame_drops=0.
- Reset asserted mid-frame returns to IDLE in one cycle, discards FIFO contents, and emits no further pulses.
- frame_start in cycle t → clear_start high in cycle t+1.
- clear_done in cycle t with the FIFO non-empty → pop at t+1 → draw_en at t+2.
- draw_done in cycle t (non-last) → draw_en at t+2 if the FIFO is non-empty.
- draw_done for the last command in cycle t → swap_buffer at t+1; base_addr shows the new value from t+2.
- draw_* operands are valid in the draw_en cycle and remain stable until the next pop.
- Occupancy counter width is $clog2(FIFO_DEPTH)+1. Read and write pointers wrap modulo FIFO_DEPTH.

## Structure
- Shared package fgpa_draw_pkg holds:
  - state enum
  - opcode constants
  - BUF0/BUF1 default addresses
  - packed draw_cmd_t struct (opcode, six vertices, colour, last; 125 bits)
- Sub-module draw_cmd_fifo: synchronous single-clock, show-ahead, parameterised depth, width $bits(draw_cmd_t). Ports: push, pop, din, dout, full, empty.
- The FSM and base-address toggle live in the top module.

## Test plan
- Reset → base_addr=32'h0012C000, cmd_ready=1, all pulses 0; push 3 commands, the 3rd with cmd_last, then frame_start → exactly one clear_start, three draw_en in FIFO order with matching operands, one swap_buffer, base_addr=32'h00000000.
- Second identical frame → base_addr returns to 32'h0012C000; frame_drops=0.
- Push 8 commands with no frame_start → cmd_ready=0 after the 8th; a 9th cmd_valid is not accepted; after one pop cmd_ready=1.
- frame_start pulsed 3 times during DRAW_WAIT → frame_drops=3, no extra clear_start; 300 pulses → frame_drops=255.
- FIFO empty at clear_done → sequencer waits in FETCH (busy=1, no draw_en); a command pushed at cycle t → pop at t+1, draw_en at t+2.
- Reset asserted in DRAW_WAIT with 4 entries queued → next cycle IDLE, FIFO empty, no swap_buffer, base_addr=BUF1_ADDR; a stray draw_done afterwards has no effect.
